// File: rtl/regfile_dump_reader.sv
// Debug register-file dump reader: stalls the core, walks every register through the
// shared read port, and streams {index, value} beats. Optional checksum beat: REGDUMP_CSUM_EN.
module regfile_dump_reader #(
   parameter int REG_SIZE       = 32,
   parameter int RS_WIDTH       = 5,
   parameter int REG_DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      stall,
   output logic                      busy,
   output logic                      done,
   output logic [RS_WIDTH-1:0]       rf_addr,
   input  logic [REG_DATA_WIDTH-1:0] rf_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [RS_WIDTH-1:0]       out_addr,
   output logic [REG_DATA_WIDTH-1:0] out_data,
   output logic                      out_last
);

   // state | meaning
   // IDLE  | waiting for start; read port belongs to the core
   // READ  | rf_addr = index, capture rf_data into the beat
   // SEND  | beat valid, waiting for out_ready
   // DONE  | one-cycle done pulse before releasing the core
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_SEND = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [RS_WIDTH-1:0] LAST_IDX = RS_WIDTH'(REG_SIZE - 1);

   state_t                      state_q;
   logic [RS_WIDTH-1:0]         idx_q;
   logic                        busy_q;
   logic                        done_q;
   logic                        out_valid_q;
   logic                        out_last_q;
   logic [RS_WIDTH-1:0]         out_addr_q;
   logic [REG_DATA_WIDTH-1:0]   out_data_q;
`ifdef REGDUMP_CSUM_EN
   logic [REG_DATA_WIDTH-1:0]   csum_q;
   logic                        csum_beat_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
`ifdef REGDUMP_CSUM_EN
         csum_q      <= '0;
         csum_beat_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_READ;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
`ifdef REGDUMP_CSUM_EN
                  csum_q      <= '0;
                  csum_beat_q <= 1'b0;
`endif
               end
            end
            S_READ: begin
               out_data_q  <= rf_data;
               out_addr_q  <= idx_q;
               out_valid_q <= 1'b1;
`ifdef REGDUMP_CSUM_EN
               out_last_q  <= 1'b0;
`else
               out_last_q  <= (idx_q == LAST_IDX);
`endif
               state_q     <= S_SEND;
            end
            S_SEND: begin
               if (out_ready) begin
`ifdef REGDUMP_CSUM_EN
                  if (csum_beat_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= S_DONE;
                  end else if (idx_q == LAST_IDX) begin
                     // stay in SEND and present the folded checksum as an extra beat
                     csum_q      <= csum_q ^ out_data_q;
                     csum_beat_q <= 1'b1;
                     out_addr_q  <= '0;
                     out_data_q  <= csum_q ^ out_data_q;
                     out_last_q  <= 1'b1;
                  end else begin
                     csum_q      <= csum_q ^ out_data_q;
                     out_valid_q <= 1'b0;
                     idx_q       <= idx_q + RS_WIDTH'(1);
                     state_q     <= S_READ;
                  end
`else
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (idx_q == LAST_IDX) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     idx_q   <= idx_q + RS_WIDTH'(1);
                     state_q <= S_READ;
                  end
`endif
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign stall     = busy_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rf_addr   = idx_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: register-file model, beat collector and per-scenario checks.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stall, busy, done;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        out_last;

   logic [31:0] rf_mem [32];

   int errors = 0;
   int checks = 0;

   // collected beats
   logic [4:0]  b_addr[$];
   logic [31:0] b_data[$];
   logic        b_last[$];
   int          b_cyc[$];
   int          done_cyc;
   int          stall_bad;
   int          unstable;

   // expected beats
   logic [4:0]  e_addr[$];
   logic [31:0] e_data[$];
   logic        e_last[$];
   int          e_cyc[$];
   int          e_done;

   regfile_dump_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stall     (stall),
      .busy      (busy),
      .done      (done),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;
   assign rf_data = rf_mem[rf_addr];

   // Expected dump: registers in order, optional XOR beat; with a ready sink the first
   // beat is cycle 2+offset, data beats every 2 cycles, checksum beat 1 cycle later.
   task automatic build_expected(input int offset);
      logic [31:0] x;
      x = 32'h0;
      e_addr.delete(); e_data.delete(); e_last.delete(); e_cyc.delete();
      for (int i = 0; i < 32; i++) begin
         e_addr.push_back(5'(i));
         e_data.push_back(rf_mem[i]);
         e_last.push_back(!CSUM && i == 31);
         e_cyc.push_back(2 + 2 * i + offset);
         x = x ^ rf_mem[i];
      end
      if (CSUM) begin
         e_addr.push_back(5'd0);
         e_data.push_back(x);
         e_last.push_back(1'b1);
         e_cyc.push_back(65 + offset);
      end
      e_done = e_cyc[e_cyc.size() - 1] + 1;
   endtask

   // Cycle 1 is the first cycle after the edge that sampled start.
   // mode 0: ready tied high, 1: random ready, 2: ready low for 100 valid cycles then high.
   task automatic collect(input int budget, input int mode, input bit keep_start);
      bit pend, r, fin;
      logic [4:0] pa;
      logic [31:0] pd;
      logic pl;
      int hold;
      b_addr.delete(); b_data.delete(); b_last.delete(); b_cyc.delete();
      done_cyc = -1; stall_bad = 0; unstable = 0;
      pend = 1'b0; fin = 1'b0; hold = 0; pa = '0; pd = '0; pl = 1'b0;
      for (int c = 1; c <= budget && !fin; c++) begin
         @(negedge clk);
         if (!keep_start) start = 1'b0;
         if (stall !== 1'b1 || busy !== 1'b1) stall_bad++;
         if (done === 1'b1) begin
            done_cyc = c;
            fin = 1'b1;
         end else begin
            if (pend && (out_valid !== 1'b1 || out_addr !== pa || out_data !== pd || out_last !== pl))
               unstable++;
            case (mode)
               0: r = 1'b1;
               1: r = 1'($urandom_range(0, 1));
               default: begin
                  r = (hold >= 100);
                  if (out_valid === 1'b1 && !r) hold++;
               end
            endcase
            out_ready = r;
            pend = (out_valid === 1'b1) && !r;
            pa = out_addr; pd = out_data; pl = out_last;
            if (out_valid === 1'b1 && r) begin
               b_addr.push_back(out_addr);
               b_data.push_back(out_data);
               b_last.push_back(out_last);
               b_cyc.push_back(c);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b1; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b stall=%b expected 0", busy, stall); end
      checks++; if (done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_flags: done=%b valid=%b last=%b expected 0", done, out_valid, out_last); end
      checks++; if (rf_addr !== 5'd0 || out_addr !== 5'd0 || out_data !== 32'd0) begin errors++; $display("FAIL reset_data: rf_addr=%0d out_addr=%0d out_data=%h expected 0", rf_addr, out_addr, out_data); end
      start = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
   endtask

   task automatic test_full_dump;
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i) * 32'h11111111;
      build_expected(0);
      @(negedge clk); start = 1'b1;
      collect(200, 0, 1'b0);
      checks++; if (b_addr.size() != e_addr.size()) begin errors++; $display("FAIL full_count: got %0d beats expected %0d", b_addr.size(), e_addr.size()); end
      for (int k = 0; k < b_addr.size() && k < e_addr.size(); k++) begin
         checks++;
         if (b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k] || b_last[k] !== e_last[k] || b_cyc[k] != e_cyc[k]) begin
            errors++;
            $display("FAIL full_beat%0d: got a=%0d d=%h l=%b cyc=%0d expected a=%0d d=%h l=%b cyc=%0d", k, b_addr[k], b_data[k], b_last[k], b_cyc[k], e_addr[k], e_data[k], e_last[k], e_cyc[k]);
         end
      end
      checks++; if (done_cyc != e_done) begin errors++; $display("FAIL full_done_cycle: got %0d expected %0d", done_cyc, e_done); end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL full_stall: %0d cycles with stall/busy low, expected 0", stall_bad); end
      @(negedge clk);
      checks++; if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL full_idle_after: stall=%b busy=%b done=%b expected 0", stall, busy, done); end
   endtask

   task automatic test_random_ready;
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      build_expected(0);
      @(negedge clk); start = 1'b1;
      collect(2000, 1, 1'b0);
      checks++; if (b_addr.size() != e_addr.size()) begin errors++; $display("FAIL rand_count: got %0d beats expected %0d", b_addr.size(), e_addr.size()); end
      for (int k = 0; k < b_addr.size() && k < e_addr.size(); k++) begin
         checks++;
         if (b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k] || b_last[k] !== e_last[k]) begin
            errors++;
            $display("FAIL rand_beat%0d: got a=%0d d=%h l=%b expected a=%0d d=%h l=%b", k, b_addr[k], b_data[k], b_last[k], e_addr[k], e_data[k], e_last[k]);
         end
      end
      checks++; if (unstable != 0) begin errors++; $display("FAIL rand_stable: %0d unstable stalled cycles, expected 0", unstable); end
      checks++; if (done_cyc < 0 || stall_bad != 0) begin errors++; $display("FAIL rand_done: done_cyc=%0d stall_bad=%0d expected done seen and 0", done_cyc, stall_bad); end
      @(negedge clk); out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_dump;
      bit found;
      int done_seen;
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      @(negedge clk); start = 1'b1; out_ready = 1'b1;
      found = 1'b0;
      for (int g = 0; g < 100 && !found; g++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid === 1'b1 && out_addr === 5'd7) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL midrst_reach: beat 7 not seen, expected within 100 cycles"); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_flags: valid=%b busy=%b stall=%b done=%b expected 0", out_valid, busy, stall, done); end
      checks++; if (out_addr !== 5'd0 || out_data !== 32'd0 || rf_addr !== 5'd0) begin errors++; $display("FAIL midrst_data: out_addr=%0d out_data=%h rf_addr=%0d expected 0", out_addr, out_data, rf_addr); end
      rst = 1'b1;
      done_seen = 0;
      repeat (4) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) done_seen++; end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL midrst_quiet: %0d cycles with done/busy after reset, expected 0", done_seen); end
      build_expected(0);
      start = 1'b1;
      collect(200, 0, 1'b0);
      checks++; if (b_addr.size() != e_addr.size() || b_addr.size() == 0) begin errors++; $display("FAIL midrst_redump_count: got %0d beats expected %0d", b_addr.size(), e_addr.size()); end
      for (int k = 0; k < b_addr.size() && k < e_addr.size(); k++) begin
         checks++;
         if (b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k] || b_cyc[k] != e_cyc[k]) begin
            errors++;
            $display("FAIL midrst_beat%0d: got a=%0d d=%h cyc=%0d expected a=%0d d=%h cyc=%0d", k, b_addr[k], b_data[k], b_cyc[k], e_addr[k], e_data[k], e_cyc[k]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_start_held;
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      build_expected(0);
      @(negedge clk); start = 1'b1; out_ready = 1'b1;
      for (int d = 0; d < 2; d++) begin
         collect(200, 0, 1'b1);
         checks++; if (done_cyc != e_done || b_addr.size() != e_addr.size()) begin errors++; $display("FAIL held_dump%0d: done_cyc=%0d beats=%0d expected %0d and %0d", d, done_cyc, b_addr.size(), e_done, e_addr.size()); end
         for (int k = 0; k < b_addr.size() && k < e_addr.size(); k++) begin
            checks++;
            if (b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k] || b_cyc[k] != e_cyc[k]) begin
               errors++;
               $display("FAIL held_dump%0d_beat%0d: got a=%0d d=%h cyc=%0d expected a=%0d d=%h cyc=%0d", d, k, b_addr[k], b_data[k], b_cyc[k], e_addr[k], e_data[k], e_cyc[k]);
            end
         end
         @(negedge clk);
         checks++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL held_idle%0d: busy=%b stall=%b done=%b expected 0", d, busy, stall, done); end
      end
      start = 1'b0;
      // let the third dump started by the held start run out
      for (int g = 0; g < 200 && done !== 1'b1; g++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_stall_long;
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      build_expected(100);
      @(negedge clk); start = 1'b1;
      collect(400, 2, 1'b0);
      checks++; if (b_addr.size() == 0 || b_cyc[0] != 102 || b_data[0] !== rf_mem[0]) begin errors++; $display("FAIL long_first: beats=%0d first_cyc=%0d expected cyc 102 data %h", b_addr.size(), (b_cyc.size() > 0) ? b_cyc[0] : -1, rf_mem[0]); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL long_stable: %0d unstable stalled cycles, expected 0", unstable); end
      checks++; if (done_cyc != e_done) begin errors++; $display("FAIL long_done: got %0d expected %0d", done_cyc, e_done); end
      for (int k = 0; k < b_addr.size() && k < e_addr.size(); k++) begin
         checks++;
         if (b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k] || b_last[k] !== e_last[k]) begin
            errors++;
            $display("FAIL long_beat%0d: got a=%0d d=%h l=%b expected a=%0d d=%h l=%b", k, b_addr[k], b_data[k], b_last[k], e_addr[k], e_data[k], e_last[k]);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
      test_reset;
      test_full_dump;
      test_random_ready;
      test_reset_mid_dump;
      test_start_held;
      test_stall_long;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
